// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared types and constants for the multi-cycle MIPS DIV/DIVU unit.
//   div_state_t : controller states (IDLE/BUSY/DONE)
//   DIV_ITERS   : restoring iterations per operation
//   CNT_W       : iteration counter width
//   mag()       : two's-complement magnitude helper
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Magnitude of a value that is negative when neg is set; wraps mod 2^32,
  // so -2^31 maps onto itself, which the unsigned datapath reads as 2^31.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step: one combinational restoring-division iteration.
//   rem_i/quo_i : current {remainder, quotient} pair
//   dvs_i       : divisor magnitude
//   rem_o/quo_o : pair after shift, trial subtract and quotient-bit insert
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted remainder needs one extra bit; the difference needs one more
  // so its MSB is a clean borrow flag.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs_i};

  always_comb begin
    if (!diff[WIDTH+1]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: multi-cycle 32-bit divider for MIPS DIV/DIVU (execute stage).
//   clk, resetn         : clock, asynchronous active-low reset
//   div_start           : valid DIV/DIVU in execute
//   div_signed          : 1 = DIV, 0 = DIVU
//   a, b                : dividend (rs), divisor (rt)
//   flush               : exception flush, aborts any operation
//   stall_all           : global freeze, holds the DONE state
//   div_stall           : hold request to the hazard unit
//   hi, lo              : registered remainder / quotient
//   div_done            : hi/lo hold a new result this cycle
// Optional feature: define DIV_EARLY_OUT_EN to finish divide-by-zero and
// |b| > |a| operations straight from IDLE (one-cycle stall).
// -----------------------------------------------------------------------------
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             stall_all,
  output logic             div_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_done
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0] rem_nx, quo_nx, a_mag, b_mag, hi_fix, lo_fix;
  logic             a_neg, b_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  assign a_neg = div_signed & a[WIDTH-1];
  assign b_neg = div_signed & b[WIDTH-1];
  assign a_mag = mag(a, a_neg);
  assign b_mag = mag(b, b_neg);

  // Sign fix applied to the final iteration. A zero divisor leaves the
  // remainder equal to |a| (so hi becomes a after the fix), but the quotient
  // must be forced to all ones regardless of the sign mode.
  assign hi_fix = r_neg_q ? (WIDTH'(0) - rem_nx) : rem_nx;
  assign lo_fix = dbz_q ? '1 : (q_neg_q ? (WIDTH'(0) - quo_nx) : quo_nx);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (div_start) begin
          q_neg_d = div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_d = a_neg;
          dbz_d   = (b == '0);
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
          // Quotient is trivially 0 (or all ones for a zero divisor) and the
          // remainder is the dividend itself, sign included.
          if ((b == '0) || (b_mag > a_mag)) begin
            hi_d    = a;
            lo_d    = (b == '0) ? '1 : '0;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
          hi_d    = hi_fix;
          lo_d    = lo_fix;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!stall_all) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything, including a completion in the same cycle.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_done  = (state_q == DONE);
  assign div_stall = ~flush & (((state_q == IDLE) & div_start) | (state_q == BUSY));

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit: directed self-checking bench for div_unit. Inputs change 1 time
// unit after the rising edge; outputs are sampled 2 time units after it.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall_all;
  logic        div_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_done;

  int n_pass  = 0;
  int n_total = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = 33;
`endif
  localparam int LAT_FULL = 33;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .stall_all  (stall_all),
    .div_stall  (div_stall),
    .hi         (hi),
    .lo         (lo),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one operation, measure latency and stall length, check the result.
  // With hold > 0, stall_all is held high for that many cycles from DONE.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat, input int hold);
    int cyc;
    int stall_cnt;
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = sgn;
    a          = av;
    b          = bv;
    #1;
    stall_cnt = div_stall ? 1 : 0;
    cyc       = 0;
    while (cyc < 100 && !div_done) begin
      @(posedge clk); #1;
      div_start = 1'b0;
      #1;
      cyc++;
      if (!div_done && div_stall) stall_cnt++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_stall_len"}, 32'(stall_cnt), 32'(exp_lat));
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_done"}, 32'(div_done), 32'd1);
    check({tag, "_stall_at_done"}, 32'(div_stall), 32'd0);
    if (hold > 0) begin
      stall_all = 1'b1;
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); #2;
        check({tag, "_held_done"}, 32'(div_done), 32'd1);
        check({tag, "_held_stall"}, 32'(div_stall), 32'd0);
        check({tag, "_held_lo"}, lo, exp_lo);
        check({tag, "_held_hi"}, hi, exp_hi);
      end
      @(posedge clk); #1;
      stall_all = 1'b0;
      #1;
      check({tag, "_held_last_done"}, 32'(div_done), 32'd1);
    end
    @(posedge clk); #2;
    check({tag, "_exit_done"}, 32'(div_done), 32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    a          = '0;
    b          = '0;
    flush      = 1'b0;
    stall_all  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_done", 32'(div_done), 32'd0);
    check("reset_stall", 32'(div_stall), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Main function
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_FULL, 0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_FULL, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT_FULL, 0);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT_FULL, 0);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, LAT_FULL, 0);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, LAT_FULL, 0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, LAT_SHORT, 0);
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_SHORT, 0);
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, LAT_SHORT, 0);
    run_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, LAT_SHORT, 0);

    // Flush mid-operation: prior result 14/2 must survive
    run_div("pre_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_FULL, 0);
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = 1'b0;
    a          = 32'd1000;
    b          = 32'd3;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall_drop", 32'(div_stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_idle_stall", 32'(div_stall), 32'd0);
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #2;
        if (div_done) done_seen++;
      end
      check("flush_no_done", 32'(done_seen), 32'd0);
    end
    check("flush_lo_kept", lo, 32'd14);
    check("flush_hi_kept", hi, 32'd2);

    // Held completion under stall_all
    run_div("held", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, LAT_FULL, 3);

    // Reset during BUSY
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = 1'b0;
    a          = 32'd77;
    b          = 32'd5;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_busy_hi", hi, 32'd0);
    check("rst_busy_lo", lo, 32'd0);
    check("rst_busy_done", 32'(div_done), 32'd0);
    check("rst_busy_stall", 32'(div_stall), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Normal operation after reset
    run_div("post_rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, LAT_FULL, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the MIPS `DIV`/`DIVU` instructions. It sits in the execute stage and produces the `div_stall` request that the hazard unit uses to freeze fetch/decode. It also obeys the hazard unit's exception flush and global memory stall. Results go to HI (remainder) and LO (quotient).

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `div_start`  in  1  execute-stage instruction is a valid DIV/DIVU.
- `div_signed`  in  1  1 = DIV (signed), 0 = DIVU.
- `a`  in  32  dividend (rs).
- `b`  in  32  divisor (rt).
- `flush`  in  1  exception flush (isexc); aborts the operation.
- `stall_all`  in  1  global pipeline freeze.
- `div_stall`  out  1  pipeline must hold; division in progress.
- `hi`  out  32  remainder, registered.
- `lo`  out  32  quotient, registered.
- `div_done`  out  1  1 in the cycle `hi`/`lo` hold a new result.

## Operation
FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `div_start & ~flush`: latch operand magnitudes, the quotient sign (`div_signed & (a[31]^b[31])`) and the remainder sign (`div_signed & a[31]`).
  - Clear the counter and go to BUSY.
- **BUSY**
  - One restoring step per cycle: shift the {rem, quo} pair left, trial-subtract the divisor magnitude, set the quotient bit if the result is non-negative.
  - After the 32nd step (counter = 31): sign-fix, register into `hi`/`lo`, go to DONE.
- **DONE**
  - `div_done`=1 and `div_stall`=0.
  - Stay in DONE while `stall_all`=1; otherwise go to IDLE.
- **Sign fix**
  - Quotient is negated if its sign bit is set.
  - Remainder is negated if the dividend was negative.
  - All arithmetic wraps mod 2^32, so -2^31 / -1 gives lo=0x8000_0000, hi=0.
- **Divide by zero**
  - Result is lo=0xFFFF_FFFF, hi=a, regardless of sign mode.
- **`div_stall`** = `~flush & ((IDLE & div_start) | BUSY)`.
- **`flush`** in any state: next state is IDLE; `hi`/`lo` are not updated; the counter is cleared.
- **`stall_all`** in BUSY does not pause iteration.
- `hi`/`lo` hold their last result until the next DONE.

## Timing
- Cycle 0: IDLE, sampling `div_start`. Cycles 1–32: BUSY. Cycle 33: DONE, result visible.
- `div_stall` is high in cycles 0–32 (33 cycles). It falls combinationally in the cycle `flush` rises.
- The next `div_start` is accepted in the cycle after DONE exits.
- Reset values:
  - state = IDLE, counter = 0.
  - `hi` = 0, `lo` = 0, `div_done` = 0, `div_stall` = 0 (given `div_start` = 0).
- Reset mid-operation aborts immediately; no partial result is written.
- `flush` and completion in the same cycle: flush wins; there is no DONE and no write.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - If the divisor is 0, or |b| > |a| (magnitudes, after sign handling), IDLE goes directly to DONE.
  - Result is lo=0 (or 0xFFFF_FFFF for divisor 0) and hi=a.
  - `div_stall` is high for cycle 0 only; DONE is in cycle 1.
- Not defined: every operation takes the full 32 BUSY cycles. Results are identical in both cases.

## Structure
- Shared package `div_pkg`:
  - `div_state_t` enum (IDLE/BUSY/DONE).
  - `DIV_ITERS` = 32.
  - Counter width constant = 5.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: {rem, quo}, divisor.
  - Outputs: next {rem, quo}.
  - Instantiated once inside `div_unit`.

## Test plan
- **DIVU 100/7:** `div_start`=1 for one cycle → `div_stall` high for 33 cycles; cycle 33 gives lo=14, hi=2, `div_done`=1.
- **DIV -7/2** (a=0xFFFF_FFF9, b=2) → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- **DIV 0x8000_0000 / 0xFFFF_FFFF** → lo=0x8000_0000, hi=0.
- **DIVU 5/0:**
  - Result lo=0xFFFF_FFFF, hi=5.
  - DONE at cycle 33 without `DIV_EARLY_OUT_EN`; cycle 1 with it.
- **Flush mid-operation:** prior result lo=14, hi=2; `flush` at cycle 10 → `div_stall`=0 that cycle, IDLE next cycle, lo/hi stay 14/2, no `div_done`.
- **Held completion:** `stall_all` high for 3 cycles starting at DONE → `div_done` stays 1, `div_stall` stays 0, hi/lo stable; IDLE one cycle after `stall_all` drops. Also: assert `resetn` low during BUSY → all outputs 0 immediately.
